fht_input_loader: RTL and testbench
===================================

// Module: fht_input_loader
// PURPOSE
//  Front-end writer for the 1024-point FHT core: accepts a valid/ready sample stream,
//  writes each frame into the 4 data RAM banks (256 words each) in bit-reversed order,
//  then pulses the FHT start strobe and holds off new input until the FHT reports ready.
//  Sits between the sample source and the bank RAM write ports / fht_control iSTART/oRDY.
// PARAMETERS
//  A_BIT   8    bank address width (256 words per bank)
//  D_BIT   16   sample width
//  N_BIT   10   frame index width (N = 2**N_BIT = 1024 points = 4 banks * 2**A_BIT)
// PORTS
//  iCLK       in   1      clock
//  iRESET     in   1      asynchronous active-low reset
//  iDATA      in   D_BIT  input sample
//  iVALID     in   1      iDATA valid
//  oREADY     out  1      loader accepts sample this cycle (transfer = iVALID & oREADY)
//  iFHT_RDY   in   1      FHT idle/done (fht_control oRDY)
//  oSTART     out  1      one-cycle start strobe to fht_control iSTART
//  oDATA      out  D_BIT  write data to all banks
//  oADDR_WR   out  A_BIT  bank write address
//  oWE        out  4      per-bank write enable, one-hot or zero
//  oBUSY      out  1      high from first accepted sample until FHT done (states LOAD..WAIT_DONE with cnt>0 or beyond LOAD)
//  oCNT       out  N_BIT  number of samples accepted in current frame
// BEHAVIOUR
//  Reset: state IDLE; oSTART=0, oWE=0, oADDR_WR=0, oDATA=0, oCNT=0, oBUSY=0; oREADY=0.
//  FSM (registered state): IDLE -> LOAD -> START -> WAIT_BUSY -> WAIT_DONE -> LOAD.
//   IDLE: wait iFHT_RDY=1, then LOAD.
//   LOAD: oREADY=1 (combinational from state only, never from iVALID). Each transfer:
//    k=oCNT; r=bitrev_N_BIT(k) (ifdef); next cycle oWE[r[1:0]]=1, oADDR_WR=r[N_BIT-1:2],
//    oDATA=iDATA; oCNT<=k+1. Write latency: 1 cycle after transfer; oWE low otherwise.
//    Transfer with k=1023 -> state START, oCNT wraps to 0, oREADY low next cycle.
//    iVALID while oREADY=0 is ignored (source must hold data; no loss, no write).
//   START: oSTART=1 for exactly this cycle (also carries last write's oWE). -> WAIT_BUSY.
//   WAIT_BUSY: stay until iFHT_RDY=0, then WAIT_DONE.
//   WAIT_DONE: stay until iFHT_RDY=1, then LOAD (next frame).
//  oBUSY: 1 when state in {START,WAIT_BUSY,WAIT_DONE} or (LOAD and oCNT!=0).
//  Gaps in iVALID allowed anywhere in a frame; no timeout.
//  iFHT_RDY dropping while in LOAD (external start): ignored, frame loading continues.
//  Reset mid-frame: partial frame discarded, all outputs to reset values next edge-free cycle.
//  Bank RAM contents are not cleared by this block.
// CONFIGURATION
//  FHT_LOAD_BITREV_EN defined: r = bit-reversed k (bank = r[1:0], addr = r[9:2]).
//  Not defined: r = k (natural order: bank = k[1:0], addr = k[9:2]); all else identical.
// TESTING
//  1 Reset, iFHT_RDY=1, stream 1024 samples data=k back-to-back -> with BITREV_EN,
//    k=1: oWE=4'b0001, oADDR_WR=8'h80; k=2: oWE=4'b0001,addr=8'h40; k=512: oWE=4'b0010,addr=0;
//    oSTART single pulse 1 cycle after last oWE-cycle start; oREADY=0 after 1024th transfer.
//  2 Same without BITREV_EN -> k=5: oWE=4'b0010, addr=8'h01; k=1023: oWE=4'b1000, addr=8'hFF.
//  3 Random iVALID gaps (50%) -> exactly 1024 write pulses, each bank/address written once,
//    oCNT monotonic, no write while iVALID=0.
//  4 After oSTART, model iFHT_RDY low 1 cycle later for 5000 cycles -> oREADY=0 and oWE=0
//    throughout; oREADY=1 1 cycle after iFHT_RDY returns high; second frame loads normally.
//  5 Assert iRESET after 300 samples -> oCNT=0, oWE=0, oBUSY=0, oSTART never pulses;
//    after release full frame loads from k=0.
//  6 iFHT_RDY=0 out of reset -> stays IDLE, oREADY=0 until iFHT_RDY=1.

Source files
------------

// File: rtl/fht_input_loader.sv
// Sample-stream front end for the 1024-point FHT: writes one frame into the four
// data banks, strobes the FHT start and waits for it to finish. FHT_LOAD_BITREV_EN selects bit-reversed placement.
module fht_input_loader #(
   parameter int A_BIT = 8,
   parameter int D_BIT = 16,
   parameter int N_BIT = 10
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic [D_BIT-1:0] iDATA,
   input  logic             iVALID,
   output logic             oREADY,
   input  logic             iFHT_RDY,
   output logic             oSTART,
   output logic [D_BIT-1:0] oDATA,
   output logic [A_BIT-1:0] oADDR_WR,
   output logic [3:0]       oWE,
   output logic             oBUSY,
   output logic [N_BIT-1:0] oCNT
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             ready_q, ready_d;
   logic             start_q, start_d;
   logic             busy_q, busy_d;
   logic [D_BIT-1:0] data_q, data_d;
   logic [A_BIT-1:0] addr_q, addr_d;
   logic [3:0]       we_q, we_d;
   logic [N_BIT-1:0] cnt_q, cnt_d;
   logic [N_BIT-1:0] slot;
   logic             xfer;

`ifdef FHT_LOAD_BITREV_EN
   function automatic logic [N_BIT-1:0] bitrev(input logic [N_BIT-1:0] v);
      logic [N_BIT-1:0] r;
      for (int i = 0; i < N_BIT; i++) r[i] = v[N_BIT-1-i];
      return r;
   endfunction
   assign slot = bitrev(cnt_q);
`else
   assign slot = cnt_q;
`endif

   // Ready comes from state only, so a transfer never depends on iVALID combinationally.
   assign xfer = iVALID && (state_q == S_LOAD);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      we_d    = 4'b0000;
      start_d = 1'b0;
      case (state_q)
         S_IDLE:      if (iFHT_RDY) state_d = S_LOAD;
         S_LOAD: begin
            if (xfer) begin
               we_d   = 4'b0001 << slot[1:0];
               addr_d = slot[N_BIT-1:2];
               data_d = iDATA;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  state_d = S_START;
                  start_d = 1'b1;
               end
            end
         end
         S_START:     state_d = S_WAIT_BUSY;
         S_WAIT_BUSY: if (!iFHT_RDY) state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (iFHT_RDY) state_d = S_LOAD;
         default:     state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_LOAD);
      busy_d  = (state_d == S_START) || (state_d == S_WAIT_BUSY) ||
                (state_d == S_WAIT_DONE) || ((state_d == S_LOAD) && (cnt_d != '0));
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         we_q    <= 4'b0000;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
      end
   end

   assign oREADY   = ready_q;
   assign oSTART   = start_q;
   assign oBUSY    = busy_q;
   assign oDATA    = data_q;
   assign oADDR_WR = addr_q;
   assign oWE      = we_q;
   assign oCNT     = cnt_q;

endmodule

// File: tb/tb_fht_input_loader.sv
// Directed bench for fht_input_loader: per-sample placement table, gap/hold/reset sequences.
module tb_fht_input_loader;

   logic        iCLK = 1'b0;
   logic        iRESET, iVALID, iFHT_RDY;
   logic [15:0] iDATA;
   logic        oREADY, oSTART, oBUSY;
   logic [15:0] oDATA;
   logic [7:0]  oADDR_WR;
   logic [3:0]  oWE;
   logic [9:0]  oCNT;

   fht_input_loader dut (
      .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
      .iFHT_RDY(iFHT_RDY), .oSTART(oSTART), .oDATA(oDATA), .oADDR_WR(oADDR_WR),
      .oWE(oWE), .oBUSY(oBUSY), .oCNT(oCNT)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      int         k;
      logic [3:0] we;
      logic [7:0] addr;
   } vec_t;
   vec_t vecs[6];

   int checks = 0, failures = 0;
   int nwr, nstart, bad_wr, bad_cnt, bad_hold;
   bit f1, hold_chk;
   logic [9:0]  prev_cnt;
   int          hits [1024];
   logic [15:0] mem  [1024];
   logic [3:0]  rec_we  [1024];
   logic [7:0]  rec_addr[1024];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int slot_of(input int k);
      logic [9:0] v, r;
      v = 10'(k);
`ifdef FHT_LOAD_BITREV_EN
      for (int i = 0; i < 10; i++) r[i] = v[9-i];
`else
      r = v;
`endif
      return int'(r);
   endfunction

   task automatic clr();
      for (int i = 0; i < 1024; i++) hits[i] = 0;
      nwr = 0;
   endtask

   // One clock; observe the registered outputs 1 time unit after the edge.
   task automatic step();
      logic x;
      int   bi, s;
      x = iVALID && oREADY;
      @(posedge iCLK);
      #1;
      if (oWE != 4'b0000) begin
         nwr++;
         if (!x || $countones(oWE) != 1) bad_wr++;
         bi = 0;
         for (int b = 0; b < 4; b++) if (oWE[b]) bi = b;
         s = {oADDR_WR, 2'(bi)};
         hits[s]++;
         mem[s] = oDATA;
         if (f1) begin
            rec_we[oDATA[9:0]]   = oWE;
            rec_addr[oDATA[9:0]] = oADDR_WR;
         end
      end
      if (oSTART) nstart++;
      if (oCNT != prev_cnt && oCNT != prev_cnt + 10'd1) bad_cnt++;
      prev_cnt = oCNT;
      if (hold_chk && (oREADY || oWE != 4'b0000)) bad_hold++;
   endtask

   task automatic stream(input logic [15:0] base, input bit gaps, input int n);
      int k, cyc;
      logic x;
      k = 0;
      cyc = 0;
      while (k < n && cyc < 20000) begin
         iVALID = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         iDATA  = iVALID ? (base | 16'(k)) : 16'hDEAD;
         x = iVALID && oREADY;
         step();
         if (x) k++;
         cyc++;
      end
      iVALID = 1'b0;
      chk("stream_samples", k, n);
   endtask

   task automatic check_frame(input string name, input logic [15:0] base);
      int errs, s;
      errs = 0;
      for (int k = 0; k < 1024; k++) begin
         s = slot_of(k);
         if (hits[s] != 1 || mem[s] != (base | 16'(k))) errs++;
      end
      chk(name, errs, 0);
   endtask

   initial begin
`ifdef FHT_LOAD_BITREV_EN
      vecs[0] = '{1,    4'b0001, 8'h80};
      vecs[1] = '{2,    4'b0001, 8'h40};
      vecs[2] = '{512,  4'b0010, 8'h00};
      vecs[3] = '{5,    4'b0001, 8'hA0};
      vecs[4] = '{3,    4'b0001, 8'hC0};
      vecs[5] = '{1023, 4'b1000, 8'hFF};
`else
      vecs[0] = '{1,    4'b0010, 8'h00};
      vecs[1] = '{2,    4'b0100, 8'h00};
      vecs[2] = '{512,  4'b0001, 8'h80};
      vecs[3] = '{5,    4'b0010, 8'h01};
      vecs[4] = '{3,    4'b1000, 8'h00};
      vecs[5] = '{1023, 4'b1000, 8'hFF};
`endif
      nstart = 0; bad_wr = 0; bad_cnt = 0; bad_hold = 0;
      f1 = 1'b0; hold_chk = 1'b0; prev_cnt = '0;
      clr();
      iRESET = 1'b0; iFHT_RDY = 1'b0; iVALID = 1'b0; iDATA = '0;
      repeat (2) @(posedge iCLK);
      #1;
      chk("rst_start", int'(oSTART), 0);
      chk("rst_we", int'(oWE), 0);
      chk("rst_addr", int'(oADDR_WR), 0);
      chk("rst_data", int'(oDATA), 0);
      chk("rst_cnt", int'(oCNT), 0);
      chk("rst_busy", int'(oBUSY), 0);
      chk("rst_ready", int'(oREADY), 0);

      // FHT not ready out of reset: loader must stay idle even with iVALID high.
      iRESET = 1'b1;
      iVALID = 1'b1;
      hold_chk = 1'b1;
      repeat (5) step();
      hold_chk = 1'b0;
      iVALID = 1'b0;
      chk("idle_hold", bad_hold, 0);
      iFHT_RDY = 1'b1;
      step();
      chk("idle_to_load_ready", int'(oREADY), 1);
      chk("load_busy_cnt0", int'(oBUSY), 0);

      // Frame 1: back-to-back, data = k.
      clr();
      f1 = 1'b1;
      stream(16'h0000, 1'b0, 1024);
      f1 = 1'b0;
      chk("f1_start", int'(oSTART), 1);
      chk("f1_ready_low", int'(oREADY), 0);
      chk("f1_last_we", int'(oWE), 8);
      chk("f1_cnt_wrap", int'(oCNT), 0);
      chk("f1_busy", int'(oBUSY), 1);
      chk("f1_nstart", nstart, 1);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("vec_we_k%0d", vecs[i].k), int'(rec_we[vecs[i].k]), int'(vecs[i].we));
         chk($sformatf("vec_addr_k%0d", vecs[i].k), int'(rec_addr[vecs[i].k]), int'(vecs[i].addr));
      end
      chk("f1_nwr", nwr, 1024);
      check_frame("f1_map", 16'h0000);
      step();
      chk("start_one_cycle", int'(oSTART), 0);

      // Long FHT run: no acceptance and no writes while it computes.
      iFHT_RDY = 1'b0;
      iVALID = 1'b1;
      hold_chk = 1'b1;
      repeat (5000) step();
      hold_chk = 1'b0;
      iVALID = 1'b0;
      chk("fht_hold", bad_hold, 0);
      chk("fht_hold_busy", int'(oBUSY), 1);
      chk("fht_hold_nstart", nstart, 1);
      iFHT_RDY = 1'b1;
      step();
      chk("done_ready", int'(oREADY), 1);

      // Frame 2: random gaps.
      clr();
      nstart = 0;
      stream(16'h8000, 1'b1, 1024);
      chk("f2_nstart", nstart, 1);
      chk("f2_nwr", nwr, 1024);
      check_frame("f2_map", 16'h8000);
      chk("f2_write_without_xfer", bad_wr, 0);
      chk("f2_cnt_monotonic", bad_cnt, 0);
      step();
      iFHT_RDY = 1'b0;
      repeat (3) step();
      iFHT_RDY = 1'b1;
      step();
      chk("f2_done_ready", int'(oREADY), 1);

      // Frame 3: reset after 300 samples, then a full frame from k=0.
      clr();
      nstart = 0;
      stream(16'h2000, 1'b0, 300);
      chk("f3_cnt300", int'(oCNT), 300);
      iRESET = 1'b0;
      #1;
      prev_cnt = '0;
      chk("midrst_cnt", int'(oCNT), 0);
      chk("midrst_we", int'(oWE), 0);
      chk("midrst_busy", int'(oBUSY), 0);
      chk("midrst_ready", int'(oREADY), 0);
      repeat (4) step();
      iRESET = 1'b1;
      step();
      chk("midrst_nstart", nstart, 0);
      clr();
      stream(16'h4000, 1'b0, 1024);
      chk("f4_nstart", nstart, 1);
      chk("f4_nwr", nwr, 1024);
      check_frame("f4_map", 16'h4000);
      chk("all_write_without_xfer", bad_wr, 0);
      chk("all_cnt_monotonic", bad_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
